qq_rd_adr_ctl: RTL
==================

// Module: qq_rd_adr_ctl
// PURPOSE
//  QuickQ v2 address controller. Owns write and read pointers for a circular
//  store of D entries, with modulo-D wrap (D need not be a power of 2).
//  The read pointer advances by a variable step of 0..MAXINC per cycle, and can
//  flush (sync) to the write pointer. Keeps an occupancy count and EMPTY/PART/FULL state.
//  Sits between the QuickQ control FSM and the storage array address inputs.
// PARAMETERS
//  D       4  queue depth in entries, >=2, any integer
//  MAXINC  2  largest read step per cycle, 1..D
//  (local) AW=$clog2(D), CW=$clog2(D+1), NW=$clog2(MAXINC+1)
// PORTS
//  clk      in   1   clock, all state updates on posedge
//  rst      in   1   reset, synchronous, active-high
//  push     in   1   request to write one entry at wr_addr this cycle
//  mode     in   2   read op: 00 HOLD, 01 ADVANCE, 10 SYNC, 11 reserved
//  incr     in   NW  ADVANCE step n, 0..MAXINC
//  push_acc out  1   combinational: push & !full (entry written this cycle)
//  wr_addr  out  AW  registered write pointer
//  rd_addr  out  AW  registered read pointer
//  count    out  CW  registered occupancy, 0..D
//  empty    out  1   state==S_EMPTY
//  full     out  1   state==S_FULL
//  err      out  1   sticky misuse flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: wr_addr=0, rd_addr=0, count=0, state=S_EMPTY, err=0. rst wins over all inputs.
//  - All outputs except push_acc are registered; effects are visible 1 cycle after the request.
//  - Push: if push_acc, wr_addr<=(wr_addr+1) mod D. A push while full is dropped.
//  - ADVANCE: n_eff=min(incr,count), using the registered count.
//    - An entry pushed this cycle cannot be popped this cycle.
//    - rd_addr<=(rd_addr+n_eff) mod D.
//    - incr=0 is HOLD.
//  - SYNC (flush): rd_addr<=wr_addr (pre-push value) and count<=push_acc.
//    - incr is ignored. A same-cycle push is retained.
//  - HOLD / mode 11: rd_addr unchanged.
//  - Count: otherwise count<=count+push_acc-n_eff. Never leaves 0..D.
//  - State: S_EMPTY (count 0), S_PART (0<count<D), S_FULL (count D).
//    - The next state is computed from the next count. Any-to-any transitions are legal,
//      e.g. FULL->EMPTY on ADVANCE with incr>=D.
//  - Modulo add: sum=a+b in AW+1 bits; if sum>=D subtract D. Valid because b<=D.
// CONFIGURATION
//  QQ_ADR_ERR_EN defined: err sets (sticky until rst) on any of these:
//    - push while full
//    - ADVANCE with incr>count
//    - incr>MAXINC
//    - mode 11
//  QQ_ADR_ERR_EN undefined: err tied 0 and no error logic is generated.
//    Clamping and drop behaviour is identical either way.
// STRUCTURE
//  - Package qq_adr_pkg:
//    - typedef enum logic[1:0] rd_mode_t {RM_HOLD,RM_ADV,RM_SYNC,RM_RSVD}
//    - typedef enum logic[1:0] q_state_t {S_EMPTY,S_PART,S_FULL}
//  - Sub-module qq_mod_add #(D,AW): combinational (a+b) mod D.
//    Two instances: read pointer and write pointer.
// TESTING (D=5, MAXINC=3, QQ_ADR_ERR_EN defined unless noted)
//  1 rst for 2 cycles -> wr=0, rd=0, count=0, empty=1, full=0, err=0.
//  2 push x5 -> wr 1,2,3,4,0; count=5, full=1.
//    6th push -> push_acc=0, wr stays 0, err=1 (err=0 with macro undefined).
//  3 From full, rd=0: ADVANCE incr=3 -> rd=3, count=2.
//    Next ADVANCE incr=3 -> n_eff=2, rd=0 (wrap), count=0, empty=1, err=1.
//  4 count=2, rd=1, wr=3: push + ADVANCE incr=1 -> rd=2, wr=4, count=2, state S_PART.
//  5 wr=2, rd=4, count=3: SYNC + push -> rd=2, wr=3, count=1.
//  6 Mid-stream: rst with push + ADVANCE incr=2 and err=1 -> next cycle all outputs
//    at reset values, err=0.

Source files
------------

// File: rtl/qq_adr_pkg.sv
// qq_adr_pkg: shared types for the QuickQ v2 address controller.
// Holds the read-operation encoding, the queue occupancy state and
// the helper that derives the state from an occupancy count.
package qq_adr_pkg;

    typedef enum logic [1:0] {
        RM_HOLD = 2'b00,
        RM_ADV  = 2'b01,
        RM_SYNC = 2'b10,
        RM_RSVD = 2'b11
    } rd_mode_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_PART  = 2'b01,
        S_FULL  = 2'b10
    } q_state_t;

    // Occupancy state for a given count in a queue of the given depth.
    function automatic q_state_t q_state_of(input int unsigned cnt, input int unsigned depth);
        if (cnt == 0)
            return S_EMPTY;
        else if (cnt >= depth)
            return S_FULL;
        else
            return S_PART;
    endfunction

endpackage

// File: rtl/qq_mod_add.sv
// qq_mod_add: combinational (a + b) mod D for queue pointers.
// a is a pointer in 0..D-1 and b is at most D, so a single conditional
// subtraction of D is enough to bring the sum back into range.
module qq_mod_add #(
    parameter int D  = 4,
    parameter int AW = 2
) (
    input  logic [AW-1:0] i_a,
    input  logic [AW:0]   i_b,
    output logic [AW-1:0] o_sum
);

    localparam logic [AW:0] DL = (AW+1)'(D);

    logic [AW:0] w_sum;
    logic [AW:0] w_wrap;

    // One extra bit holds the raw sum; wrap it once if it reached D.
    always_comb begin
        w_sum  = {1'b0, i_a} + i_b;
        w_wrap = w_sum - DL;
        if (w_sum >= DL)
            o_sum = w_wrap[AW-1:0];
        else
            o_sum = w_sum[AW-1:0];
    end

endmodule

// File: rtl/qq_rd_adr_ctl.sv
// qq_rd_adr_ctl: QuickQ v2 address controller.
// Owns the write and read pointers of a D-entry circular store (any D >= 2),
// the occupancy count and the EMPTY/PART/FULL state. The read pointer moves
// by 0..MAXINC per cycle or flushes to the write pointer.
// Optional feature: define QQ_ADR_ERR_EN to build the sticky misuse flag;
// without it err is tied low and no error logic exists.
module qq_rd_adr_ctl
    import qq_adr_pkg::*;
#(
    parameter  int D      = 4,
    parameter  int MAXINC = 2,
    localparam int AW     = $clog2(D),
    localparam int CW     = $clog2(D + 1),
    localparam int NW     = $clog2(MAXINC + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [1:0]    mode,
    input  logic [NW-1:0] incr,
    output logic          push_acc,
    output logic [AW-1:0] wr_addr,
    output logic [AW-1:0] rd_addr,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          err
);

    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    q_state_t      r_state;
    q_state_t      w_state_nxt;

    rd_mode_t      w_mode;
    logic          w_push_acc;
    logic [CW-1:0] w_incr_ext;
    logic [CW-1:0] w_n_eff;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] w_wr_inc;
    logic [AW-1:0] w_rd_adv;
    logic [AW-1:0] w_rd_nxt;

    assign w_mode     = rd_mode_t'(mode);
    assign w_push_acc = push & (r_state != S_FULL);
    assign w_incr_ext = CW'(incr);

    // Effective read step: clamp to the registered count, so an entry
    // written this cycle can never be consumed in the same cycle.
    always_comb begin
        w_n_eff = '0;
        if (w_mode == RM_ADV) begin
            if (w_incr_ext > r_cnt)
                w_n_eff = r_cnt;
            else
                w_n_eff = w_incr_ext;
        end
    end

    qq_mod_add #(.D(D), .AW(AW)) u_wr_add (
        .i_a   (r_wr),
        .i_b   ((AW+1)'(w_push_acc)),
        .o_sum (w_wr_inc)
    );

    qq_mod_add #(.D(D), .AW(AW)) u_rd_add (
        .i_a   (r_rd),
        .i_b   ((AW+1)'(w_n_eff)),
        .o_sum (w_rd_adv)
    );

    // Next read pointer and occupancy; SYNC flushes to the pre-push write
    // pointer and keeps only a same-cycle accepted push.
    always_comb begin
        w_rd_nxt  = r_rd;
        w_cnt_nxt = r_cnt + CW'(w_push_acc) - w_n_eff;
        if (w_mode == RM_SYNC) begin
            w_rd_nxt  = r_wr;
            w_cnt_nxt = CW'(w_push_acc);
        end else if (w_mode == RM_ADV) begin
            w_rd_nxt  = w_rd_adv;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            r_wr  <= w_wr_inc;
            r_rd  <= w_rd_nxt;
            r_cnt <= w_cnt_nxt;
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_EMPTY;
        else
            r_state <= w_state_nxt;
    end

    // Next state follows the next count, so any-to-any moves are possible.
    always_comb begin
        w_state_nxt = r_state;
        case (q_state_of(32'(w_cnt_nxt), D))
            S_EMPTY: w_state_nxt = S_EMPTY;
            S_FULL:  w_state_nxt = S_FULL;
            default: w_state_nxt = S_PART;
        endcase
    end

`ifdef QQ_ADR_ERR_EN
    logic r_err;
    logic w_err_evt;
    logic w_incr_ovr;

    // An out-of-range step only exists when the incr field can encode it.
    if (MAXINC < (2 ** NW) - 1) begin : g_ovr
        assign w_incr_ovr = (incr > NW'(MAXINC));
    end else begin : g_no_ovr
        assign w_incr_ovr = 1'b0;
    end

    // Any misuse seen this cycle.
    always_comb begin
        w_err_evt = 1'b0;
        if (push && (r_state == S_FULL))
            w_err_evt = 1'b1;
        if ((w_mode == RM_ADV) && (w_incr_ext > r_cnt))
            w_err_evt = 1'b1;
        if (w_incr_ovr)
            w_err_evt = 1'b1;
        if (w_mode == RM_RSVD)
            w_err_evt = 1'b1;
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else
            r_err <= r_err | w_err_evt;
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign push_acc = w_push_acc;
    assign wr_addr  = r_wr;
    assign rd_addr  = r_rd;
    assign count    = r_cnt;
    assign empty    = (r_state == S_EMPTY);
    assign full     = (r_state == S_FULL);

endmodule
